// File: rtl/caravel_sram_scan_pkg.sv
// Shared widths, scan-register field layout and command payload for the SRAM scan controller.
package caravel_sram_scan_pkg;

    localparam int unsigned NUM_MACROS = 16;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MASK_W     = 4;
    localparam int unsigned SCAN_W     = 112;

    // sel[3] set means a single-port macro (no port 1)
    localparam int unsigned SP_SEL_MSB = 3;

    // Macros physically fitted, one bit per sel value
    localparam logic [NUM_MACROS-1:0] FITTED_MASK = '1;

    // Scan register field offsets (LSB position of each field)
    localparam int unsigned SEL_LSB    = 108;
    localparam int unsigned ADDR0_LSB  = 92;
    localparam int unsigned DIN0_LSB   = 60;
    localparam int unsigned CSB0_BIT   = 59;
    localparam int unsigned WEB0_BIT   = 58;
    localparam int unsigned WMASK0_LSB = 54;
    localparam int unsigned ADDR1_LSB  = 38;
    localparam int unsigned DIN1_LSB   = 6;
    localparam int unsigned CSB1_BIT   = 5;
    localparam int unsigned WEB1_BIT   = 4;
    localparam int unsigned WMASK1_LSB = 0;

    // Command payload as seen in the scan register, MSB first
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr0;
        logic [DATA_W-1:0] din0;
        logic              csb0;
        logic              web0;
        logic [MASK_W-1:0] wmask0;
        logic [ADDR_W-1:0] addr1;
        logic [DATA_W-1:0] din1;
        logic              csb1;
        logic              web1;
        logic [MASK_W-1:0] wmask1;
    } scan_cmd_t;

endpackage

// File: rtl/caravel_sram_scan_if.sv
// GPIO scan pins and shared SRAM bus between the scan controller and the macros.
interface caravel_sram_scan_if;
    import caravel_sram_scan_pkg::*;

    logic                         in_select;
    logic                         gpio_in;
    logic                         gpio_scan;
    logic                         gpio_sram_load;
    logic                         global_csb;
    logic                         gpio_out;
    logic [ADDR_W-1:0]            sram_addr0;
    logic [ADDR_W-1:0]            sram_addr1;
    logic [DATA_W-1:0]            sram_din0;
    logic                         sram_web0;
    logic [MASK_W-1:0]            sram_wmask0;
    logic [NUM_MACROS-1:0]        sram_csb0;
    logic [NUM_MACROS-1:0]        sram_csb1;
    logic [NUM_MACROS*DATA_W-1:0] sram_dout0;
    logic [NUM_MACROS*DATA_W-1:0] sram_dout1;

    // Controller side
    modport master (
        input  in_select, gpio_in, gpio_scan, gpio_sram_load, global_csb,
        input  sram_dout0, sram_dout1,
        output gpio_out, sram_addr0, sram_addr1, sram_din0, sram_web0,
        output sram_wmask0, sram_csb0, sram_csb1
    );

    // Pin / macro side
    modport slave (
        output in_select, gpio_in, gpio_scan, gpio_sram_load, global_csb,
        output sram_dout0, sram_dout1,
        input  gpio_out, sram_addr0, sram_addr1, sram_din0, sram_web0,
        input  sram_wmask0, sram_csb0, sram_csb1
    );

endinterface

// File: rtl/caravel_sram_scan_cmd_decode.sv
// Macro select decode: per-macro chip selects and read-data mux.
module sram_cmd_decode
    import caravel_sram_scan_pkg::*;
(
    input  logic [SEL_W-1:0]             sel,
    input  logic                         exec_en,
    input  logic                         csb0_fld,
    input  logic                         csb1_fld,
    input  logic [NUM_MACROS*DATA_W-1:0] dout0,
    input  logic [NUM_MACROS*DATA_W-1:0] dout1,
    output logic [NUM_MACROS-1:0]        csb0_c,
    output logic [NUM_MACROS-1:0]        csb1_c,
    output logic [DATA_W-1:0]            rdata0_c,
    output logic [DATA_W-1:0]            rdata1_c
);

    logic fitted_c;

    // One-hot active-low chip select for the selected macro, plus its read data
    always_comb begin
        csb0_c   = '1;
        csb1_c   = '1;
        rdata0_c = '0;
        rdata1_c = '0;
        fitted_c = FITTED_MASK[sel];
        for (int k = 0; k < NUM_MACROS; k++) begin
            if (fitted_c && (SEL_W'(k) == sel)) begin
                if (exec_en) begin
                    csb0_c[k] = csb0_fld;
                    // Single-port macros have no port 1
                    if (!sel[SP_SEL_MSB]) begin
                        csb1_c[k] = csb1_fld;
                    end
                end
                rdata0_c = dout0[k*DATA_W +: DATA_W];
                rdata1_c = dout1[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/caravel_sram_scan.sv
// GPIO-driven SRAM test controller: 112-bit scan command register, execute strobe and read-back load.
module caravel_sram_scan
    import caravel_sram_scan_pkg::*;
(
    input  logic                    gpio_clk,
    input  logic                    resetn,
    caravel_sram_scan_if.master     bus
);

    logic [SCAN_W-1:0]     scan_q;
    logic [SCAN_W-1:0]     scan_d;
    logic                  exec_en_c;
    logic [DATA_W-1:0]     rdata0_c;
    logic [DATA_W-1:0]     rdata1_c;
    logic [NUM_MACROS-1:0] csb0_c;
    logic [NUM_MACROS-1:0] csb1_c;

    // Execute only when idle on the scan side; reset blocks any access
    assign exec_en_c = bus.in_select & ~bus.global_csb & ~bus.gpio_scan
                     & ~bus.gpio_sram_load & resetn;

    sram_cmd_decode u_decode (
        .sel      (scan_q[SEL_LSB +: SEL_W]),
        .exec_en  (exec_en_c),
        .csb0_fld (scan_q[CSB0_BIT]),
        .csb1_fld (scan_q[CSB1_BIT]),
        .dout0    (bus.sram_dout0),
        .dout1    (bus.sram_dout1),
        .csb0_c   (csb0_c),
        .csb1_c   (csb1_c),
        .rdata0_c (rdata0_c),
        .rdata1_c (rdata1_c)
    );

    // Next scan value: load has priority over shift, otherwise hold
    always_comb begin
        scan_d = scan_q;
        if (bus.in_select) begin
            if (bus.gpio_sram_load) begin
                scan_d[DIN0_LSB +: DATA_W] = rdata0_c;
                scan_d[DIN1_LSB +: DATA_W] = rdata1_c;
            end else if (bus.gpio_scan) begin
                scan_d = {scan_q[SCAN_W-2:0], bus.gpio_in};
            end
        end
    end

    // Scan register, cleared asynchronously so a partial command is discarded
    always_ff @(posedge gpio_clk or negedge resetn) begin
        if (!resetn) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end

    assign bus.gpio_out    = scan_q[SCAN_W-1];
    assign bus.sram_addr0  = scan_q[ADDR0_LSB +: ADDR_W];
    assign bus.sram_addr1  = scan_q[ADDR1_LSB +: ADDR_W];
    assign bus.sram_din0   = scan_q[DIN0_LSB +: DATA_W];
    assign bus.sram_web0   = scan_q[WEB0_BIT];
    assign bus.sram_wmask0 = scan_q[WMASK0_LSB +: MASK_W];
    assign bus.sram_csb0   = csb0_c;
    assign bus.sram_csb1   = csb1_c;

endmodule

// File: tb/tb_caravel_sram_scan.sv
// Self-checking bench for caravel_sram_scan with a behavioural model of 16 SRAM macros.
module tb_caravel_sram_scan;
    import caravel_sram_scan_pkg::*;

    logic gpio_clk;
    logic resetn;
    int   total;
    int   bad;
    int   csb_leak;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;
    exp_t exp_q[$];

    caravel_sram_scan_if bus ();

    caravel_sram_scan dut (
        .gpio_clk (gpio_clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    initial gpio_clk = 1'b0;
    always #5 gpio_clk = ~gpio_clk;

    // Macro model: 0-7 dual-port, 8-15 single-port, 256 words, 1-cycle read latency
    logic [31:0] mem [16][256];
    logic [31:0] dout0_r [16];
    logic [31:0] dout1_r [16];

    initial begin
        for (int k = 0; k < 16; k++) begin
            dout0_r[k] = '0;
            dout1_r[k] = '0;
            for (int a = 0; a < 256; a++) mem[k][a] = '0;
        end
    end

    always @(posedge gpio_clk) begin
        for (int k = 0; k < 16; k++) begin
            if (bus.sram_csb0[k] == 1'b0) begin
                if (bus.sram_web0 == 1'b0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.sram_wmask0[b])
                            mem[k][bus.sram_addr0[7:0]][8*b +: 8] <= bus.sram_din0[8*b +: 8];
                    end
                end else begin
                    dout0_r[k] <= mem[k][bus.sram_addr0[7:0]];
                end
            end
            if (k < 8 && bus.sram_csb1[k] == 1'b0)
                dout1_r[k] <= mem[k][bus.sram_addr1[7:0]];
        end
    end

    always_comb begin
        bus.sram_dout0 = '0;
        bus.sram_dout1 = '0;
        for (int k = 0; k < 16; k++) begin
            bus.sram_dout0[k*32 +: 32] = dout0_r[k];
            bus.sram_dout1[k*32 +: 32] = dout1_r[k];
        end
    end

    function automatic logic [111:0] mk_cmd(input int s, input logic [15:0] a0,
                                            input logic [31:0] d0, input logic c0,
                                            input logic w0, input logic [3:0] m0,
                                            input logic [15:0] a1, input logic c1);
        scan_cmd_t c;
        c        = '0;
        c.sel    = 4'(s);
        c.addr0  = a0;
        c.din0   = d0;
        c.csb0   = c0;
        c.web0   = w0;
        c.wmask0 = m0;
        c.addr1  = a1;
        c.csb1   = c1;
        c.web1   = 1'b1;
        return c;
    endfunction

    function automatic logic [15:0] one_low(input int s);
        return ~(16'd1 << s);
    endfunction

    function automatic logic [31:0] tag(input int s, input int n);
        return (32'(s) << 24) | 32'(n);
    endfunction

    task automatic tick();
        @(posedge gpio_clk);
        #1;
    endtask

    task automatic shift_in(input logic [111:0] v);
        for (int i = 111; i >= 0; i--) begin
            bus.gpio_in   = v[i];
            bus.gpio_scan = 1'b1;
            #1;
            if (bus.sram_csb0 !== 16'hFFFF || bus.sram_csb1 !== 16'hFFFF) csb_leak++;
            @(posedge gpio_clk);
            #1;
        end
        bus.gpio_scan = 1'b0;
        bus.gpio_in   = 1'b0;
    endtask

    task automatic shift_out(output logic [111:0] got);
        for (int i = 111; i >= 0; i--) begin
            got[i]        = bus.gpio_out;
            bus.gpio_in   = 1'b0;
            bus.gpio_scan = 1'b1;
            tick();
        end
        bus.gpio_scan = 1'b0;
    endtask

    task automatic exec_cmd(input logic [15:0] e0, input logic [15:0] e1, input string nm);
        bus.global_csb = 1'b0;
        #1;
        total++;
        if (bus.sram_csb0 !== e0 || bus.sram_csb1 !== e1) begin
            bad++;
            $display("FAIL %s: csb0=%h csb1=%h, expected csb0=%h csb1=%h",
                     nm, bus.sram_csb0, bus.sram_csb1, e0, e1);
        end
        @(posedge gpio_clk);
        #1;
        bus.global_csb = 1'b1;
    endtask

    // Pop one expected read result, capture read data and compare the shifted-out fields
    task automatic check_read();
        exp_t        e;
        logic [111:0] got;
        scan_cmd_t   c;
        bus.gpio_sram_load = 1'b1;
        tick();
        bus.gpio_sram_load = 1'b0;
        shift_out(got);
        c = scan_cmd_t'(got);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got din0=%h din1=%h, expected a queued entry", c.din0, c.din1);
        end else begin
            e = exp_q.pop_front();
            if (c.din0 !== e.d0) begin
                bad++;
                $display("FAIL read_din0 sel=%0d: got %h expected %h", e.sel, c.din0, e.d0);
            end
            total++;
            if (c.din1 !== e.d1) begin
                bad++;
                $display("FAIL read_din1 sel=%0d: got %h expected %h", e.sel, c.din1, e.d1);
            end
        end
    endtask

    task automatic test_reset();
        logic [111:0] got;
        resetn = 1'b0;
        bus.global_csb = 1'b0;
        #2;
        total++;
        if (bus.gpio_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_gpio_out: got %b expected 0", bus.gpio_out);
        end
        total++;
        if (bus.sram_csb0 !== 16'hFFFF || bus.sram_csb1 !== 16'hFFFF) begin
            bad++;
            $display("FAIL reset_csb: got %h/%h expected ffff/ffff", bus.sram_csb0, bus.sram_csb1);
        end
        bus.global_csb = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        shift_out(got);
        total++;
        if (got !== 112'd0) begin
            bad++;
            $display("FAIL reset_scan_reg: got %h expected 0", got);
        end
    endtask

    task automatic test_dual_port();
        for (int s = 0; s <= 4; s++) begin
            shift_in(mk_cmd(s, 16'd1, tag(s, 1), 1'b0, 1'b0, 4'hF, 16'd0, 1'b1));
            exec_cmd(one_low(s), 16'hFFFF, "dual_write1");
            shift_in(mk_cmd(s, 16'd2, tag(s, 2), 1'b0, 1'b0, 4'hF, 16'd0, 1'b1));
            exec_cmd(one_low(s), 16'hFFFF, "dual_write2");
        end
        for (int s = 0; s <= 4; s++) begin
            shift_in(mk_cmd(s, 16'd1, 32'd0, 1'b0, 1'b1, 4'h0, 16'd2, 1'b0));
            exp_q.push_back('{sel: 4'(s), d0: tag(s, 1), d1: tag(s, 2)});
            exec_cmd(one_low(s), one_low(s), "dual_read");
            check_read();
        end
    endtask

    task automatic test_single_port();
        for (int s = 8; s <= 11; s++) begin
            shift_in(mk_cmd(s, 16'd1, tag(s, 1), 1'b0, 1'b0, 4'hF, 16'd1, 1'b0));
            exec_cmd(one_low(s), 16'hFFFF, "sp_write");
            shift_in(mk_cmd(s, 16'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0101, 16'd1, 1'b0));
            exec_cmd(one_low(s), 16'hFFFF, "sp_masked_write");
            shift_in(mk_cmd(s, 16'd1, 32'd0, 1'b0, 1'b1, 4'h0, 16'd1, 1'b0));
            exp_q.push_back('{sel: 4'(s), d0: tag(s, 1) | 32'h00FF_00FF, d1: 32'd0});
            exec_cmd(one_low(s), 16'hFFFF, "sp_read");
            check_read();
        end
    endtask

    task automatic test_scan_priority();
        logic [111:0] cmd;
        logic [111:0] got;
        scan_cmd_t    e;
        cmd = mk_cmd(2, 16'd1, 32'h1234_5678, 1'b0, 1'b1, 4'h0, 16'd2, 1'b0);
        csb_leak = 0;
        bus.global_csb = 1'b0;
        shift_in(cmd);
        bus.global_csb = 1'b1;
        total++;
        if (csb_leak !== 0) begin
            bad++;
            $display("FAIL shift_no_exec: got %0d cycles with csb asserted, expected 0", csb_leak);
        end
        exec_cmd(one_low(2), one_low(2), "prio_read");
        bus.gpio_scan = 1'b1;
        bus.gpio_sram_load = 1'b1;
        bus.gpio_in = 1'b1;
        tick();
        bus.gpio_scan = 1'b0;
        bus.gpio_sram_load = 1'b0;
        bus.gpio_in = 1'b0;
        e = scan_cmd_t'(cmd);
        e.din0 = tag(2, 1);
        e.din1 = tag(2, 2);
        shift_out(got);
        total++;
        if (got !== 112'(e)) begin
            bad++;
            $display("FAIL load_over_scan: got %h expected %h", got, 112'(e));
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [111:0] got;
        for (int i = 0; i < 40; i++) begin
            bus.gpio_in = 1'b1;
            bus.gpio_scan = 1'b1;
            tick();
        end
        bus.gpio_scan = 1'b0;
        bus.gpio_in = 1'b0;
        bus.global_csb = 1'b0;
        resetn = 1'b0;
        #1;
        total++;
        if (bus.sram_csb0 !== 16'hFFFF || bus.sram_csb1 !== 16'hFFFF) begin
            bad++;
            $display("FAIL reset_mid_csb: got %h/%h expected ffff/ffff", bus.sram_csb0, bus.sram_csb1);
        end
        bus.global_csb = 1'b1;
        tick();
        resetn = 1'b1;
        tick();
        shift_out(got);
        total++;
        if (got !== 112'd0) begin
            bad++;
            $display("FAIL reset_mid_scan_reg: got %h expected 0", got);
        end
    endtask

    task automatic test_freeze();
        logic [111:0] cmd;
        logic [111:0] got;
        cmd = mk_cmd(5, 16'($urandom), 32'($urandom), 1'b0, 1'b1, 4'($urandom), 16'($urandom), 1'b0);
        shift_in(cmd);
        bus.in_select = 1'b0;
        bus.global_csb = 1'b0;
        csb_leak = 0;
        for (int i = 0; i < 8; i++) begin
            bus.gpio_in = 1'b1;
            bus.gpio_scan = (i % 2 == 0);
            bus.gpio_sram_load = (i % 3 == 0);
            if (i == 7) begin
                bus.gpio_scan = 1'b0;
                bus.gpio_sram_load = 1'b0;
            end
            #1;
            if (bus.sram_csb0 !== 16'hFFFF || bus.sram_csb1 !== 16'hFFFF) csb_leak++;
            tick();
        end
        total++;
        if (csb_leak !== 0) begin
            bad++;
            $display("FAIL deselect_csb: got %0d cycles with csb asserted, expected 0", csb_leak);
        end
        bus.global_csb = 1'b1;
        bus.gpio_scan = 1'b0;
        bus.gpio_sram_load = 1'b0;
        bus.gpio_in = 1'b0;
        bus.in_select = 1'b1;
        shift_out(got);
        total++;
        if (got !== cmd) begin
            bad++;
            $display("FAIL deselect_freeze: got %h expected %h", got, cmd);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        csb_leak = 0;
        resetn = 1'b0;
        bus.in_select = 1'b1;
        bus.gpio_in = 1'b0;
        bus.gpio_scan = 1'b0;
        bus.gpio_sram_load = 1'b0;
        bus.global_csb = 1'b1;
        test_reset();
        test_dual_port();
        test_single_port();
        test_scan_priority();
        test_reset_mid_shift();
        test_freeze();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
